gray_bit_packer: RTL and testbench

Runtime-configurable bit packer that sits after the symbol-to-gray-bits demapper in the OFDM receive chain. It accepts one demapped symbol per beat, carrying 1..MAX_BPS bits, and packs the bits MSB-first into OUT_WIDTH-bit AXI-stream words.
It supports any bits-per-symbol value, including non-power-of-two values such as 3 and 5. It flushes a partial final word on i_tlast and reports how many bits in that word are valid. Backpressure is correct throughout.

---
 rtl/gray_bit_packer_pkg.sv | 32 +++
 rtl/bit_accumulator.sv | 68 ++++++
 rtl/gray_bit_packer.sv | 171 +++++++++++++++++
 tb/tb_gray_bit_packer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_bit_packer_pkg.sv
// ============================================================================
// Module      : gray_bit_packer_pkg
// Description : Shared types and helpers for the gray-bit packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_bit_packer_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Accumulator width for the default geometry (OUT_WIDTH=32, MAX_BPS=8).
  localparam int unsigned ACC_W = 32 + 8 - 1;

  function automatic int unsigned acc_width(input int unsigned out_width,
                                            input int unsigned max_bps);
    return out_width + max_bps - 1;
  endfunction

  function automatic int unsigned clamp_bps(input int unsigned raw,
                                            input int unsigned max_bps);
    if (raw == 0) return 1;
    else if (raw > max_bps) return max_bps;
    else return raw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_accumulator.sv
// ============================================================================
// Module      : bit_accumulator
// Description : MSB-first shift-in / word-extract datapath with fill count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_accumulator
  import gray_bit_packer_pkg::*;
#(
  parameter int unsigned MAX_BPS   = 8,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned BPS_W     = $clog2(MAX_BPS) + 1,
  parameter int unsigned FILL_W    = $clog2(acc_width(OUT_WIDTH, MAX_BPS) + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic                 i_extract,
  input  logic                 i_zero,
  input  logic [MAX_BPS-1:0]   i_sym,
  input  logic [BPS_W-1:0]     i_bps,
  output logic [FILL_W-1:0]    o_fill,
  output logic [FILL_W-1:0]    o_new_fill,
  output logic [OUT_WIDTH-1:0] o_word
);

  localparam int unsigned ACC_LEN = acc_width(OUT_WIDTH, MAX_BPS);

  logic [ACC_LEN-1:0] r_acc;
  logic [FILL_W-1:0]  r_fill;
  logic [ACC_LEN-1:0] w_placed;
  logic [ACC_LEN-1:0] w_merged;
  logic [MAX_BPS-1:0] w_mask;

  // Bits below the fill point are kept zero, so extracted words come out
  // already zero-padded.
  always_comb begin
    w_mask   = ~({MAX_BPS{1'b1}} >> i_bps);
    w_placed = '0;
    w_placed[ACC_LEN-1 -: MAX_BPS] = i_sym & w_mask;
    w_placed = w_placed >> r_fill;
    w_merged   = i_push ? (r_acc | w_placed) : r_acc;
    o_new_fill = i_push ? (r_fill + FILL_W'(i_bps)) : r_fill;
  end

  assign o_fill = r_fill;
  assign o_word = w_merged[ACC_LEN-1 -: OUT_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else if (i_zero) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else if (i_extract) begin
      r_acc  <= w_merged << OUT_WIDTH;
      r_fill <= o_new_fill - FILL_W'(OUT_WIDTH);
    end else if (i_push) begin
      r_acc  <= w_merged;
      r_fill <= o_new_fill;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gray_bit_packer.sv
// ============================================================================
// Module      : gray_bit_packer
// Description : Packs 1..MAX_BPS-bit symbols MSB-first into AXI-stream words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_bit_packer
  import gray_bit_packer_pkg::*;
#(
  parameter int unsigned MAX_BPS     = 8,
  parameter int unsigned OUT_WIDTH   = 32,
  parameter int unsigned SR_BPS      = 0,
  parameter int unsigned DEFAULT_BPS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           set_stb,
  input  logic [7:0]                     set_addr,
  input  logic [31:0]                    set_data,
  input  logic [MAX_BPS-1:0]             i_tdata,
  input  logic                           i_tlast,
  input  logic                           i_tvalid,
  output logic                           i_tready,
  output logic [OUT_WIDTH-1:0]           o_tdata,
  output logic                           o_tlast,
  output logic [$clog2(OUT_WIDTH):0]     o_tuser,
  output logic                           o_tvalid,
  input  logic                           o_tready
);

  localparam int unsigned BPS_W   = $clog2(MAX_BPS) + 1;
  localparam int unsigned ACC_LEN = acc_width(OUT_WIDTH, MAX_BPS);
  localparam int unsigned FILL_W  = $clog2(ACC_LEN + 1);
  localparam int unsigned USER_W  = $clog2(OUT_WIDTH) + 1;
  localparam logic [BPS_W-1:0]  BPS_RESET = BPS_W'(clamp_bps(DEFAULT_BPS, MAX_BPS));
  localparam logic [FILL_W-1:0] FILL_OW   = FILL_W'(OUT_WIDTH);
  localparam logic [USER_W-1:0] USER_OW   = USER_W'(OUT_WIDTH);

  state_e             r_state;
  state_e             w_state_next;
  logic [BPS_W-1:0]   r_bps_active;
  logic [BPS_W-1:0]   r_bps_pending;
  logic [BPS_W-1:0]   w_bps;
  logic               r_in_pkt;
  logic               w_idle;
  logic               w_out_free;
  logic               w_accept;
  logic               w_full;
  logic               w_push;
  logic               w_extract;
  logic               w_zero;
  logic               w_load;
  logic               w_load_last;
  logic [USER_W-1:0]  w_load_user;
  logic [FILL_W-1:0]  w_fill;
  logic [FILL_W-1:0]  w_new_fill;
  logic [OUT_WIDTH-1:0] w_word;
  logic               w_unused_set;

  assign w_unused_set = ^set_data[31:BPS_W];

  bit_accumulator #(
    .MAX_BPS   (MAX_BPS),
    .OUT_WIDTH (OUT_WIDTH),
    .BPS_W     (BPS_W),
    .FILL_W    (FILL_W)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_extract  (w_extract),
    .i_zero     (w_zero),
    .i_sym      (i_tdata),
    .i_bps      (w_bps),
    .o_fill     (w_fill),
    .o_new_fill (w_new_fill),
    .o_word     (w_word)
  );

  // Between packets the pending value is used directly, so a packet that
  // starts the cycle after a boundary already packs at the new rate.
  always_comb begin
    w_state_next = r_state;
    w_out_free   = ~o_tvalid | o_tready;
    w_idle       = (r_state == ACCUM) && (w_fill == '0) && !r_in_pkt;
    w_bps        = w_idle ? r_bps_pending : r_bps_active;
    i_tready     = (r_state == ACCUM) && w_out_free;
    w_accept     = i_tvalid && i_tready;
    w_full       = (w_new_fill >= FILL_OW);
    w_push       = w_accept;
    w_extract    = 1'b0;
    w_zero       = clear;
    w_load       = 1'b0;
    w_load_last  = 1'b0;
    w_load_user  = '0;
    case (r_state)
      ACCUM: begin
        if (w_accept) begin
          if (w_full) begin
            w_extract   = 1'b1;
            w_load      = 1'b1;
            w_load_user = USER_OW;
            if (i_tlast) begin
              if (w_new_fill == FILL_OW) w_load_last = 1'b1;
              else                       w_state_next = FLUSH;
            end
          end else if (i_tlast) begin
            w_load      = 1'b1;
            w_load_last = 1'b1;
            w_load_user = USER_W'(w_new_fill);
            w_zero      = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (w_out_free) begin
          w_load       = 1'b1;
          w_load_last  = 1'b1;
          w_load_user  = USER_W'(w_fill);
          w_zero       = 1'b1;
          w_state_next = ACCUM;
        end
      end
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_state <= ACCUM;
    else if (clear) r_state <= ACCUM;
    else            r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_tvalid      <= 1'b0;
      o_tdata       <= '0;
      o_tlast       <= 1'b0;
      o_tuser       <= '0;
      r_in_pkt      <= 1'b0;
      r_bps_active  <= BPS_RESET;
      r_bps_pending <= BPS_RESET;
    end else begin
      if (set_stb && (set_addr == 8'(SR_BPS)))
        r_bps_pending <= BPS_W'(clamp_bps(32'(set_data[BPS_W-1:0]), MAX_BPS));
      if (clear) begin
        o_tvalid <= 1'b0;
        o_tdata  <= '0;
        o_tlast  <= 1'b0;
        o_tuser  <= '0;
        r_in_pkt <= 1'b0;
      end else begin
        r_bps_active <= w_bps;
        if (w_accept) r_in_pkt <= !i_tlast;
        if (w_load) begin
          o_tvalid <= 1'b1;
          o_tdata  <= w_word;
          o_tlast  <= w_load_last;
          o_tuser  <= w_load_user;
        end else if (o_tready) begin
          o_tvalid <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_bit_packer.sv
// ============================================================================
// Module      : tb_gray_bit_packer
// Description : Self-checking bench for gray_bit_packer against a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_bit_packer;

  localparam int MAX_BPS = 8;
  localparam int OW      = 32;

  logic        clk = 1'b0;
  logic        reset, clear, set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [7:0]  i_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid, o_tready;
  logic [5:0]  o_tuser;

  always #5 clk = ~clk;

  gray_bit_packer #(
    .MAX_BPS(MAX_BPS), .OUT_WIDTH(OW), .SR_BPS(0), .DEFAULT_BPS(2)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tuser(o_tuser),
    .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          u;
  } word_t;

  word_t expq[$];
  word_t cap[$];
  bit    bitq[$];
  int    m_pend = 2, m_act = 2;
  bit    m_in_pkt = 0;
  int    n_cmp = 0, n_bad = 0, stall_cnt = 0;
  int    n_exp_words = 0, n_out_words = 0;
  int    rdy_mode = 0;
  bit    prev_stall = 0;
  logic [38:0] prev_out;

  function automatic int clampv(input int raw);
    if (raw == 0) return 1;
    if (raw > MAX_BPS) return MAX_BPS;
    return raw;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: symbols become a plain bit stream; words are 32-bit slices of it.
  task automatic model_beat(input logic [7:0] d, input logic last);
    word_t w;
    if (!m_in_pkt) m_act = m_pend;
    for (int k = 0; k < m_act; k++) bitq.push_back(d[7-k]);
    while (bitq.size() >= OW) begin
      w.d = '0;
      for (int k = 0; k < OW; k++) w.d[31-k] = bitq.pop_front();
      w.u = OW;
      w.l = last && (bitq.size() == 0);
      expq.push_back(w);
      n_exp_words++;
    end
    if (last && bitq.size() > 0) begin
      w.d = '0;
      w.u = bitq.size();
      for (int k = 0; k < w.u; k++) w.d[31-k] = bitq.pop_front();
      w.l = 1'b1;
      expq.push_back(w);
      n_exp_words++;
    end
    m_in_pkt = !last;
  endtask

  // Compare process: everything is sampled at the falling edge, i.e. the
  // values that the next rising edge will act on.
  always @(negedge clk) begin
    word_t w;
    word_t c;
    if (reset || clear) begin
      bitq.delete();
      expq.delete();
      m_in_pkt   = 0;
      prev_stall = 0;
      if (reset) begin
        m_pend = 2;
        m_act  = 2;
      end
    end else begin
      if (prev_stall) begin
        chk("stall_valid", o_tvalid, 1);
        chk("stall_hold", {o_tdata, o_tlast, o_tuser}, prev_out);
      end
      if (o_tvalid && o_tready) begin
        n_out_words++;
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h expected none", o_tdata);
        end else begin
          w = expq.pop_front();
          chk("word_data", o_tdata, w.d);
          chk("word_last", o_tlast, w.l);
          chk("word_user", o_tuser, w.u);
        end
        c.d = o_tdata;
        c.l = o_tlast;
        c.u = int'(o_tuser);
        cap.push_back(c);
      end
      prev_stall = o_tvalid && !o_tready;
      prev_out   = {o_tdata, o_tlast, o_tuser};
      if (i_tvalid && !i_tready) stall_cnt++;
      if (i_tvalid && i_tready) model_beat(i_tdata, i_tlast);
      if (set_stb && set_addr == 8'd0) m_pend = clampv(int'(set_data[3:0]));
    end
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 1)      o_tready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 2) o_tready = 1'b0;
      else                    o_tready = 1'b1;
    end
  end

  task automatic send(input logic [7:0] d, input logic last);
    bit ok = 0;
    i_tdata = d; i_tlast = last; i_tvalid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (i_tready) begin ok = 1; break; end
    end
    @(posedge clk);
    #2;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no i_tready expected accept");
    end
  endtask

  task automatic set_bps(input int v);
    set_stb = 1'b1; set_addr = 8'd0; set_data = 32'(v);
    @(posedge clk);
    #2;
    set_stb = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #3;
      if (expq.size() == 0 && !o_tvalid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
    end
    @(posedge clk);
    #2;
  endtask

  task automatic chk_cap(input string name, input int idx, input logic [31:0] d,
                         input logic l, input int u);
    if (cap.size() > idx) begin
      chk({name, "_data"}, cap[idx].d, d);
      chk({name, "_last"}, cap[idx].l, l);
      chk({name, "_user"}, cap[idx].u, u);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d words expected index %0d", name, cap.size(), idx);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, raw;
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    #12;
    chk("rst_valid", o_tvalid, 0);
    chk("rst_data", o_tdata, 0);
    chk("rst_last", o_tlast, 0);
    chk("rst_user", o_tuser, 0);
    @(posedge clk); #2; reset = 1'b0;
    @(posedge clk); #2;

    // bps=1, single symbol: word visible one cycle after acceptance
    set_bps(1);
    cap.delete();
    send(8'h80, 1'b1);
    chk("lat1_valid", o_tvalid, 1);
    drain();
    chk("b1_count", cap.size(), 1);
    chk_cap("b1_w0", 0, 32'h8000_0000, 1'b1, 1);

    // bps=6, 96 bits: three full words, no bubble
    set_bps(6);
    cap.delete();
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) send(8'($urandom), i == 15);
    drain();
    chk("b6_count", cap.size(), 3);
    chk("b6_stalls", stall_cnt, 0);
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      chk("b6_user", cap[i].u, 32);
      chk("b6_last", cap[i].l, i == 2);
    end

    // bps=3, 33 bits -> full word plus a one-bit flush word
    set_bps(3);
    cap.delete();
    stall_cnt = 0;
    for (int i = 0; i < 11; i++) send(8'hA0, i == 10);
    send(8'hE0, 1'b1);
    drain();
    chk("b3_count", cap.size(), 3);
    chk_cap("b3_w0", 0, 32'hB6DB_6DB6, 1'b0, 32);
    chk_cap("b3_w1", 1, 32'h8000_0000, 1'b1, 1);
    chk_cap("b3_w2", 2, 32'hE000_0000, 1'b1, 3);
    chk("b3_stalls", stall_cnt, 1);

    // bps change mid-packet applies from the next packet
    set_bps(4);
    cap.delete();
    for (int i = 0; i < 3; i++) send(8'hA0, 1'b0);
    set_bps(2);
    for (int i = 0; i < 5; i++) send(8'hA0, i == 4);
    send(8'hC0, 1'b0);
    send(8'hC0, 1'b1);
    drain();
    chk_cap("chg_w0", 0, 32'hAAAA_AAAA, 1'b1, 32);
    chk_cap("chg_w1", 1, 32'hF000_0000, 1'b1, 4);

    // clamping: 0 -> 1, 15 -> 8
    cap.delete();
    set_bps(0);
    send(8'hFF, 1'b1);
    set_bps(15);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b1);
    drain();
    chk_cap("clmp0", 0, 32'h8000_0000, 1'b1, 1);
    chk_cap("clmp15", 1, 32'hAABB_CCDD, 1'b1, 32);

    // clear mid-packet drops bits, keeps bps
    set_bps(5);
    cap.delete();
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    clear = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0;
    send(8'hF8, 1'b1);
    drain();
    chk("clr_count", cap.size(), 1);
    chk_cap("clr_w0", 0, 32'hF800_0000, 1'b1, 5);

    // random backpressure, bps=4, 64 symbols
    rdy_mode = 1;
    set_bps(4);
    for (int i = 0; i < 64; i++) begin
      send(8'($urandom), i == 63);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #2; end
    end
    drain();

    // random packets with random raw bps writes
    for (int p = 0; p < 12; p++) begin
      raw = $urandom_range(0, 15);
      set_bps(raw);
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) send(8'($urandom), i == len - 1);
    end
    drain();
    chk("conserve", n_out_words, n_exp_words);
    rdy_mode = 0;

    // async reset with a word held in the output register
    rdy_mode = 2;
    @(posedge clk); #2;
    set_bps(7);
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0);
    chk("prerst_valid", o_tvalid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", o_tvalid, 0);
    chk("arst_data", o_tdata, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #2;
    cap.delete();
    send(8'hC0, 1'b1);
    drain();
    chk("post_count", cap.size(), 1);
    chk_cap("post_w0", 0, 32'hC000_0000, 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
